// File: rtl/serial_sub_8bit_if.sv
// Start/Busy/Done request bus for the bit-serial subtractor, plus an FSM state debug tap.
interface serial_sub_8bit_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   logic [1:0]       state_dbg;

   // Handshake: start is sampled only while busy=0; an accepted request yields
   // exactly one done pulse, and diff/bout/ovf are valid from that pulse until the next one.
   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, ovf, state_dbg
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, ovf, state_dbg
   );
endinterface

// File: rtl/serial_sub_8bit.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional macro SERIAL_SUB_SAT_EN clamps diff to 0 on unsigned underflow.
module serial_sub_8bit #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   serial_sub_8bit_if.slave  bus
);
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, next_state;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic             br;
   logic [CNT_W-1:0] cnt;
   logic             a_msb, b_msb;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q, ovf_q;

   logic             accept, shift_en, last;
   logic             a0, b0, d, br_next;
   logic [WIDTH-1:0] res_next;

   assign a0       = a_sr[0];
   assign b0       = b_sr[0];
   assign d        = a0 ^ b0 ^ br;
   assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
   assign res_next = {d, res_sr[WIDTH-1:1]};

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      shift_en   = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
               last       = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            if (bus.start) begin
               accept     = 1'b1;
               next_state = SHIFT;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         diff_q <= '0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            br     <= bus.bin;
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
            res_sr <= '0;
            cnt    <= '0;
         end else if (shift_en) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            br     <= br_next;
            res_sr <= res_next;
            cnt    <= cnt + 1'b1;
         end
         // The last shift edge also publishes the result; d is the raw result MSB here.
         if (last) begin
            bout_q <= br_next;
            ovf_q  <= (a_msb != b_msb) && (d != a_msb);
`ifdef SERIAL_SUB_SAT_EN
            diff_q <= br_next ? '0 : res_next;
`else
            diff_q <= res_next;
`endif
         end
      end
   end

   assign bus.busy      = (state == SHIFT);
   assign bus.done      = (state == DONE);
   assign bus.diff      = diff_q;
   assign bus.bout      = bout_q;
   assign bus.ovf       = ovf_q;
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_serial_sub_8bit.sv
// Self-checking bench for serial_sub_8bit: scoreboard of expected {diff,bout,ovf}
// pushed on accepted requests and popped on each done pulse.
module tb_serial_sub_8bit;
   localparam int W = 8;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [W+1:0] exp_q[$];

   serial_sub_8bit_if #(.WIDTH(W)) sif ();

   serial_sub_8bit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic bin);
      logic [W:0]   full;
      logic [W-1:0] raw, res;
      logic         bo, ov;
      full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      raw  = full[W-1:0];
      bo   = full[W];
      ov   = (a[W-1] != b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef SERIAL_SUB_SAT_EN
      res  = bo ? '0 : raw;
`else
      res  = raw;
`endif
      return {res, bo, ov};
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (!reset && sif.done) begin
         logic [W+1:0] exp_v;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: got diff=%h bout=%b ovf=%b with no request outstanding",
                     sif.diff, sif.bout, sif.ovf);
         end else begin
            exp_v = exp_q.pop_front();
            if ({sif.diff, sif.bout, sif.ovf} !== exp_v) begin
               errors++;
               $display("FAIL result: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                        sif.diff, sif.bout, sif.ovf, exp_v[W+1:2], exp_v[1], exp_v[0]);
            end
         end
      end
   end

   task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      @(negedge clk);
      sif.start = 1'b1;
      sif.a     = a;
      sif.b     = b;
      sif.bin   = bin;
      exp_q.push_back(model(a, b, bin));
      @(negedge clk);
      sif.start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (sif.done !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sif.done !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: done=%b after %0d cycles, want 1", name, sif.done, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({sif.busy, sif.done, sif.diff, sif.bout, sif.ovf, sif.state_dbg} !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b ovf=%b st=%0d, want all 0",
                  sif.busy, sif.done, sif.diff, sif.bout, sif.ovf, sif.state_dbg);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_latency();
      int n;
      drive_start(8'h50, 8'h20, 1'b0);
      n = 1;  // the negedge inside drive_start already saw the first busy cycle
      checks++;
      if (sif.busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_first: busy=%b, want 1", sif.busy);
      end
      while (n < 20) begin
         @(negedge clk);
         if (sif.busy !== 1'b1) break;
         n++;
      end
      checks++;
      if (n != W || sif.done !== 1'b1) begin
         errors++;
         $display("FAIL latency: busy cycles=%0d done=%b, want %0d and 1", n, sif.done, W);
      end
      @(negedge clk);
      checks++;
      if (sif.done !== 1'b0 || sif.busy !== 1'b0 || sif.diff !== 8'h30) begin
         errors++;
         $display("FAIL done_pulse: done=%b busy=%b diff=%h, want 0 0 30",
                  sif.done, sif.busy, sif.diff);
      end
   endtask

   task automatic test_arith();
      logic [W-1:0] av[6] = '{8'h00, 8'h10, 8'h80, 8'h7F, 8'hFF, 8'h00};
      logic [W-1:0] bv[6] = '{8'h01, 8'h0F, 8'h01, 8'hFF, 8'hFF, 8'h00};
      logic         cv[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         drive_start(av[i], bv[i], cv[i]);
         wait_done("arith");
         @(negedge clk);
      end
      for (int i = 0; i < 10; i++) begin
         drive_start(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)));
         wait_done("random");
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] held;
      drive_start(8'h09, 8'h04, 1'b0);
      held = sif.diff;
      @(negedge clk);
      @(negedge clk);
      sif.start = 1'b1;
      sif.a     = 8'hFF;
      @(negedge clk);
      sif.start = 1'b0;
      checks++;
      if (sif.diff !== held) begin
         errors++;
         $display("FAIL diff_stable: diff=%h during shift, want %h", sif.diff, held);
      end
      wait_done("b2b_first");
      sif.start = 1'b1;
      sif.a     = 8'h03;
      sif.b     = 8'h01;
      sif.bin   = 1'b0;
      exp_q.push_back(model(8'h03, 8'h01, 1'b0));
      @(negedge clk);
      sif.start = 1'b0;
      checks++;
      if (sif.busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b after start on done cycle, want 1", sif.busy);
      end
      wait_done("b2b_second");
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      drive_start(8'h55, 8'h11, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      sif.start = 1'b1;  // dropped: reset wins
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      sif.start = 1'b0;
      checks++;
      if ({sif.busy, sif.done, sif.diff, sif.bout, sif.ovf} !== '0) begin
         errors++;
         $display("FAIL abort_clear: busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                  sif.busy, sif.done, sif.diff, sif.bout, sif.ovf);
      end
      repeat (12) @(negedge clk);
      drive_start(8'h22, 8'h11, 1'b0);
      wait_done("after_abort");
      @(negedge clk);
      checks++;
      if (sif.diff !== 8'h11) begin
         errors++;
         $display("FAIL after_abort_diff: diff=%h, want 11", sif.diff);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      sif.start = 1'b0;
      sif.a     = '0;
      sif.b     = '0;
      sif.bin   = 1'b0;
      test_reset();
      test_latency();
      test_arith();
      test_back_to_back();
      test_reset_abort();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
